timer_compare_unit: RTL and testbench
=====================================

# timer_compare_unit

Parametrised prescaled timer with N output-compare channels. It divides the system clock into a tick, advances a CNT_W-bit counter per tick up to a programmable top, and per channel provides a compare-match level, a sticky match flag and a PWM output. Sits between the clock domain and the display/sound/blink logic that needs low-rate events. It generalises the fixed 1024 Hz single-compare generator with a programmable top, one-shot/periodic mode, restart and several channels.

## Interface
- PRESCALE_DIV, 48828: clk cycles per tick (1024 Hz at 50 MHz); legal range ≥ 2.
- CNT_W, 10: counter and compare width.
- NCH, 2: number of compare channels.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  1 = prescaler and counter run; 0 = both hold.
- mode  in  1  0 = periodic (wrap at top), 1 = one-shot (stop at top).
- restart  in  1  synchronous pulse: prescaler and count to 0, done cleared.
- top  in  CNT_W  last count value of a period.
- ocr  in  NCH*CNT_W  compare values; channel i at bits [i*CNT_W +: CNT_W].
- clr  in  NCH  write-1-to-clear for flag[i].
- count  out  CNT_W  current counter value (registered).
- tick  out  1  one-cycle pulse, high in the cycle the counter shows a new value.
- ovf  out  1  one-cycle pulse, high in the cycle count has just wrapped top→0 (periodic only).
- done  out  1  one-shot finished; sticky until restart or reset.
- ocr_match  out  NCH  level: count == ocr_i (combinational from count and ocr).
- flag  out  NCH  sticky: set when an advance loads count == ocr_i.
- pwm  out  NCH  level: count < ocr_i (combinational, unsigned).

## Operation
- Reset (rst_n low, any time, asynchronous): prescaler, count, tick, ovf, done, flag all 0. ocr_match/pwm follow count=0.
- Priority per edge: restart > en=0 hold > normal run.
- restart: prescaler←0, count←0, done←0, tick←0, ovf←0; flags untouched (clr still applies).
- Prescaler: counts 0..PRESCALE_DIV-1 while en=1 and not stopped. At edge with prescaler == PRESCALE_DIV-1: prescaler←0 and an advance occurs.
- Advance: tick←1 for one cycle. If count ≠ top: count←count+1. If count == top: mode 0 → count←0, ovf←1; mode 1 → count holds at top, done←1, prescaler stops (no further ticks until restart).
- count > top (top lowered mid-run): next advance treats as at top (wrap or stop); no 2^CNT_W roll-through.
- Flags: flag[i] set on an advance whose new count == ocr_i. clr[i] clears; simultaneous set and clr → set wins.
- ocr_i > top: never matches, pwm[i] constantly 1. ocr_i = 0: pwm[i] constantly 0; flag set on each wrap to 0 (and after restart only via later wrap, not by restart itself).
- top = 0, mode 0: count stays 0, ovf and tick every advance.
- mode, top, ocr may change anytime; take effect at next evaluation, no glitch protection on pwm.

## Timing
- Tick period: exactly PRESCALE_DIV clk cycles while running; first tick PRESCALE_DIV cycles after reset release / restart with en=1.
- tick, ovf, flag set, done rise on the same edge as the count update they describe.
- en low for k cycles delays the next tick by exactly k cycles (prescaler holds, not cleared).
- ocr_match/pwm: zero-cycle latency from count/ocr.
- done remains 1, count remains top until restart; en toggling does not resume.

## Test plan
- PRESCALE_DIV=4, CNT_W=4, top=5, mode=0, en=1 from reset: tick every 4 cycles, count 1,2,3,4,5,0,…; ovf with the 5→0 update; first tick at cycle 4.
- Same, ocr0=3, ocr1=9: pwm0 high for counts 0–2, ocr_match0 only at 3, flag0 set with count→3; pwm1 always 1, flag1 never set.
- clr0 asserted on the same edge as flag0 set → flag0=1; clr0 one cycle later → flag0=0.
- mode=1, top=2: counts 1,2 then done=1, tick stops, count holds 2 for ≥20 cycles; restart → count 0, done 0, ticks resume after 4 cycles.
- en=0 for 3 cycles mid-period: next tick exactly 3 cycles late, count unchanged during hold.
- rst_n low asynchronously mid-period (between clk edges): all outputs 0 immediately; after release first tick after 4 cycles; top lowered to 1 while count=3 → next advance wraps to 0 with ovf.

Source files
------------

// File: rtl/timer_compare_unit_if.sv
// Control and status bundle for timer_compare_unit.
//   en, mode, restart   run enable, 0=periodic/1=one-shot, synchronous restart
//   top                 last count value of a period
//   ocr                 packed compare values, channel i at [i*CNT_W +: CNT_W]
//   clr                 write-1-to-clear for flag[i]
//   count               registered counter value
//   tick, ovf           one-cycle advance / wrap pulses
//   done                one-shot finished (sticky)
//   ocr_match, flag, pwm per-channel compare level, sticky match, PWM level
// master: controlling logic; slave: the timer.
interface timer_compare_unit_if #(
  parameter int unsigned CNT_W = 10,
  parameter int unsigned NCH   = 2
);
  logic                   en;
  logic                   mode;
  logic                   restart;
  logic [CNT_W-1:0]       top;
  logic [NCH*CNT_W-1:0]   ocr;
  logic [NCH-1:0]         clr;
  logic [CNT_W-1:0]       count;
  logic                   tick;
  logic                   ovf;
  logic                   done;
  logic [NCH-1:0]         ocr_match;
  logic [NCH-1:0]         flag;
  logic [NCH-1:0]         pwm;

  modport master (
    output en, mode, restart, top, ocr, clr,
    input  count, tick, ovf, done, ocr_match, flag, pwm
  );

  modport slave (
    input  en, mode, restart, top, ocr, clr,
    output count, tick, ovf, done, ocr_match, flag, pwm
  );
endinterface

// File: rtl/timer_compare_unit.sv
// Prescaled timer with NCH output-compare channels.
// The prescaler divides clk by PRESCALE_DIV into advances; each advance steps
// a CNT_W-bit counter up to a programmable top, then wraps (periodic) or
// stops (one-shot). Each channel gives a compare-match level, a sticky match
// flag and a PWM level (count < ocr).
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    timer_compare_unit_if.slave (control inputs, status outputs)
module timer_compare_unit #(
  parameter int unsigned PRESCALE_DIV = 48828,
  parameter int unsigned CNT_W        = 10,
  parameter int unsigned NCH          = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  timer_compare_unit_if.slave   bus
);

  localparam int unsigned      PS_W    = $clog2(PRESCALE_DIV);
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE_DIV - 1);

  typedef enum logic {
    ST_RUN,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [PS_W-1:0]   psc_q, psc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              tick_q, tick_d;
  logic              ovf_q, ovf_d;
  logic [NCH-1:0]    flag_q, flag_d;

  logic              advance;
  logic              at_top;

  // A count above top (top lowered mid-run) behaves as if at top.
  assign at_top  = (count_q >= bus.top);
  assign advance = !bus.restart && bus.en && (state_q == ST_RUN) &&
                   (psc_q == PS_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      psc_q   <= '0;
      count_q <= '0;
      tick_q  <= 1'b0;
      ovf_q   <= 1'b0;
      flag_q  <= '0;
    end else begin
      state_q <= state_d;
      psc_q   <= psc_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      ovf_q   <= ovf_d;
      flag_q  <= flag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    psc_d   = psc_q;
    count_d = count_q;
    tick_d  = 1'b0;
    ovf_d   = 1'b0;

    if (bus.restart) begin
      state_d = ST_RUN;
      psc_d   = '0;
      count_d = '0;
    end else if (bus.en && (state_q == ST_RUN)) begin
      if (psc_q == PS_LAST) begin
        psc_d  = '0;
        tick_d = 1'b1;
        if (!at_top) begin
          count_d = count_q + CNT_W'(1);
        end else if (!bus.mode) begin
          count_d = '0;
          ovf_d   = 1'b1;
        end else begin
          // One-shot end: count holds, prescaler frozen until restart.
          state_d = ST_DONE;
        end
      end else begin
        psc_d = psc_q + PS_W'(1);
      end
    end
  end

  // Set dominates clear so a match coinciding with clr is never lost.
  always_comb begin
    flag_d = flag_q & ~bus.clr;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (advance && (count_d == bus.ocr[i*CNT_W +: CNT_W])) begin
        flag_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    bus.ocr_match = '0;
    bus.pwm       = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      bus.ocr_match[i] = (count_q == bus.ocr[i*CNT_W +: CNT_W]);
      bus.pwm[i]       = (count_q <  bus.ocr[i*CNT_W +: CNT_W]);
    end
  end

  assign bus.count = count_q;
  assign bus.tick  = tick_q;
  assign bus.ovf   = ovf_q;
  assign bus.done  = (state_q == ST_DONE);
  assign bus.flag  = flag_q;

endmodule

// File: tb/tb_timer_compare_unit.sv
// Directed bench for timer_compare_unit with PRESCALE_DIV=4, CNT_W=4, NCH=2.
module tb_timer_compare_unit;
  localparam int unsigned PD = 4;
  localparam int unsigned CW = 4;
  localparam int unsigned NC = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   c;

  always #5 clk = ~clk;

  timer_compare_unit_if #(.CNT_W(CW), .NCH(NC)) bus ();

  timer_compare_unit #(
    .PRESCALE_DIV (PD),
    .CNT_W        (CW),
    .NCH          (NC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.en      = 1'b1;
    bus.mode    = 1'b0;
    bus.restart = 1'b0;
    bus.top     = 4'd5;
    bus.ocr     = {4'd9, 4'd3};
    bus.clr     = 2'b00;

    step();
    step();
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_tick",  32'(bus.tick),  32'd0);
    chk("rst_ovf",   32'(bus.ovf),   32'd0);
    chk("rst_done",  32'(bus.done),  32'd0);
    chk("rst_flag",  32'(bus.flag),  32'd0);
    chk("rst_pwm",   32'(bus.pwm),   32'd3);
    chk("rst_match", 32'(bus.ocr_match), 32'd0);
    rst_n = 1'b1;

    // Periodic run, top=5: counts 1..5,0 every 4 cycles.
    for (int k = 1; k <= 24; k++) begin
      step();
      c = (k / 4) % 6;
      chk("run_tick",  32'(bus.tick),  32'(k % 4 == 0));
      chk("run_count", 32'(bus.count), 32'(c));
      chk("run_ovf",   32'(bus.ovf),   32'((k % 4 == 0) && (c == 0)));
      chk("run_pwm",   32'(bus.pwm),   32'({1'b1, c < 3}));
      chk("run_match", 32'(bus.ocr_match), 32'({1'b0, c == 3}));
      chk("run_flag",  32'(bus.flag),  32'({1'b0, k >= 12}));
    end

    // Plain clear, then clear coincident with set.
    bus.clr = 2'b01;
    step();                                   // k=25
    chk("clr_flag", 32'(bus.flag), 32'd0);
    bus.clr = 2'b00;
    for (int k = 26; k <= 35; k++) step();
    bus.clr = 2'b01;
    step();                                   // k=36, count -> 3
    chk("setclr_count", 32'(bus.count), 32'd3);
    chk("setclr_tick",  32'(bus.tick),  32'd1);
    chk("setclr_flag",  32'(bus.flag),  32'd1);
    chk("setclr_match", 32'(bus.ocr_match), 32'd1);
    step();                                   // k=37
    chk("clr2_flag", 32'(bus.flag), 32'd0);
    bus.clr = 2'b00;

    // en low 3 cycles: next tick (normally k=40) moves to k=43.
    bus.en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold_tick",  32'(bus.tick),  32'd0);
      chk("hold_count", 32'(bus.count), 32'd3);
    end
    bus.en = 1'b1;
    step();
    chk("resume_tick0", 32'(bus.tick), 32'd0);
    step();
    chk("resume_tick1", 32'(bus.tick), 32'd0);
    step();
    chk("resume_tick",  32'(bus.tick),  32'd1);
    chk("resume_count", 32'(bus.count), 32'd4);

    // Asynchronous reset between edges, while tick is high.
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(bus.count), 32'd0);
    chk("arst_tick",  32'(bus.tick),  32'd0);
    chk("arst_flag",  32'(bus.flag),  32'd0);
    chk("arst_pwm",   32'(bus.pwm),   32'd3);
    #2;
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("post_tick",  32'(bus.tick),  32'(k % 4 == 0));
      chk("post_count", 32'(bus.count), 32'(k / 4));
    end
    chk("post_flag", 32'(bus.flag), 32'd1);

    // Lower top below the current count: next advance wraps with ovf.
    bus.top = 4'd1;
    for (int k = 0; k < 3; k++) step();
    step();
    chk("lower_count", 32'(bus.count), 32'd0);
    chk("lower_ovf",   32'(bus.ovf),   32'd1);
    chk("lower_tick",  32'(bus.tick),  32'd1);

    // One-shot, top=2.
    bus.restart = 1'b1;
    bus.mode    = 1'b1;
    bus.top     = 4'd2;
    step();
    chk("rs_count", 32'(bus.count), 32'd0);
    chk("rs_done",  32'(bus.done),  32'd0);
    chk("rs_tick",  32'(bus.tick),  32'd0);
    bus.restart = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("os_tick",  32'(bus.tick),  32'(k % 4 == 0));
      chk("os_count", 32'(bus.count), 32'((k < 12) ? k / 4 : 2));
      chk("os_done",  32'(bus.done),  32'(k == 12));
      chk("os_ovf",   32'(bus.ovf),   32'd0);
    end
    for (int j = 0; j < 20; j++) begin
      if (j == 5) bus.en = 1'b0;
      if (j == 8) bus.en = 1'b1;
      step();
      chk("stop_tick",  32'(bus.tick),  32'd0);
      chk("stop_count", 32'(bus.count), 32'd2);
      chk("stop_done",  32'(bus.done),  32'd1);
    end
    bus.restart = 1'b1;
    step();
    chk("rs2_count", 32'(bus.count), 32'd0);
    chk("rs2_done",  32'(bus.done),  32'd0);
    bus.restart = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("rs2_wait", 32'(bus.tick), 32'd0);
    end
    step();
    chk("rs2_tick",  32'(bus.tick),  32'd1);
    chk("rs2_count", 32'(bus.count), 32'd1);
    chk("rs2_done1", 32'(bus.done),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
